// File: rtl/alarm_clock_multi.sv
// Multi-alarm 24-hour HH:MM clock core with per-slot enable, snooze, dismiss and ring timeout.
// Time advances on an internal minute prescaler; a slot matching the next time starts a ring.
module alarm_clock_multi #(
    parameter int TICKS_PER_MIN = 60,
    parameter int NUM_ALARMS    = 4,
    parameter int SNOOZE_MIN    = 5,
    parameter int RING_MIN      = 2,
    parameter int IDXW          = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            set_time,
    input  logic [4:0]      set_hours,
    input  logic [5:0]      set_minutes,
    input  logic            alarm_wr,
    input  logic [IDXW-1:0] alarm_idx,
    input  logic [4:0]      alarm_hours,
    input  logic [5:0]      alarm_minutes,
    input  logic            alarm_en,
    input  logic            snooze,
    input  logic            dismiss,
    output logic [4:0]      cur_hours,
    output logic [5:0]      cur_minutes,
    output logic            minute_tick,
    output logic            ringing,
    output logic            snoozed,
    output logic [IDXW-1:0] ring_idx
);

    localparam int PW = $clog2(TICKS_PER_MIN);
    localparam int SW = $clog2(SNOOZE_MIN + 1);
    localparam int RW = $clog2(RING_MIN + 1);

    typedef enum logic [1:0] {IDLE, RINGING, SNOOZED} state_t;

    state_t          state;
    logic [PW-1:0]   presc;
    logic [SW-1:0]   snz_cnt;
    logic [RW-1:0]   ring_cnt;
    logic [4:0]      al_hours   [NUM_ALARMS];
    logic [5:0]      al_minutes [NUM_ALARMS];
    logic            al_en      [NUM_ALARMS];

    logic            set_ok;
    logic            wr_ok;
    logic            advance;
    logic [4:0]      next_hours;
    logic [5:0]      next_minutes;
    logic            hit;
    logic [IDXW-1:0] hit_idx;

    always_comb begin
        set_ok  = set_time && (set_hours <= 5'd23) && (set_minutes <= 6'd59);
        wr_ok   = alarm_wr && (alarm_hours <= 5'd23) && (alarm_minutes <= 6'd59);
        advance = !set_ok && (presc == PW'(TICKS_PER_MIN - 1));
        if (cur_minutes == 6'd59) begin
            next_minutes = '0;
            next_hours   = (cur_hours == 5'd23) ? '0 : cur_hours + 5'd1;
        end else begin
            next_minutes = cur_minutes + 6'd1;
            next_hours   = cur_hours;
        end
    end

    // Scan from the top down so the lowest matching slot is the one left standing.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int unsigned k = NUM_ALARMS; k > 0; k--) begin
            if (al_en[k-1] && al_hours[k-1] == next_hours && al_minutes[k-1] == next_minutes) begin
                hit     = 1'b1;
                hit_idx = IDXW'(k - 1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc       <= '0;
            cur_hours   <= '0;
            cur_minutes <= '0;
            minute_tick <= 1'b0;
        end else if (set_ok) begin
            presc       <= '0;
            cur_hours   <= set_hours;
            cur_minutes <= set_minutes;
            minute_tick <= 1'b0;
        end else if (advance) begin
            presc       <= '0;
            cur_hours   <= next_hours;
            cur_minutes <= next_minutes;
            minute_tick <= 1'b1;
        end else begin
            presc       <= presc + 1'b1;
            minute_tick <= 1'b0;
        end
    end

    // Slot indices at or beyond NUM_ALARMS never compare equal, so such writes fall away.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < NUM_ALARMS; k++) begin
                al_hours[k]   <= '0;
                al_minutes[k] <= '0;
                al_en[k]      <= 1'b0;
            end
        end else begin
            for (int unsigned k = 0; k < NUM_ALARMS; k++) begin
                if (wr_ok && alarm_idx == IDXW'(k)) begin
                    al_hours[k]   <= alarm_hours;
                    al_minutes[k] <= alarm_minutes;
                    al_en[k]      <= alarm_en;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ringing  <= 1'b0;
            snoozed  <= 1'b0;
            ring_idx <= '0;
            ring_cnt <= '0;
            snz_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (advance && hit) begin
                        state    <= RINGING;
                        ringing  <= 1'b1;
                        ring_idx <= hit_idx;
                        ring_cnt <= '0;
                    end
                end
                RINGING: begin
                    if (dismiss) begin
                        state   <= IDLE;
                        ringing <= 1'b0;
                    end else if (snooze) begin
                        state   <= SNOOZED;
                        ringing <= 1'b0;
                        snoozed <= 1'b1;
                        snz_cnt <= '0;
                    end else if (advance) begin
                        if (ring_cnt == RW'(RING_MIN - 1)) begin
                            state   <= IDLE;
                            ringing <= 1'b0;
                        end else begin
                            ring_cnt <= ring_cnt + 1'b1;
                        end
                    end
                end
                SNOOZED: begin
                    if (dismiss) begin
                        state   <= IDLE;
                        snoozed <= 1'b0;
                    end else if (advance) begin
                        if (snz_cnt == SW'(SNOOZE_MIN - 1)) begin
                            state    <= RINGING;
                            ringing  <= 1'b1;
                            snoozed  <= 1'b0;
                            ring_cnt <= '0;
                        end else begin
                            snz_cnt <= snz_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    ringing <= 1'b0;
                    snoozed <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alarm_clock_multi.sv
// Directed bench for alarm_clock_multi: tick timing, wrap, set/alarm writes, ring/snooze/dismiss.
module tb_alarm_clock_multi;

    logic       clk;
    logic       rst_n;
    logic       set_time;
    logic [4:0] set_hours;
    logic [5:0] set_minutes;
    logic       alarm_wr;
    logic [1:0] alarm_idx;
    logic [4:0] alarm_hours;
    logic [5:0] alarm_minutes;
    logic       alarm_en;
    logic       snooze;
    logic       dismiss;
    logic [4:0] cur_hours;
    logic [5:0] cur_minutes;
    logic       minute_tick;
    logic       ringing;
    logic       snoozed;
    logic [1:0] ring_idx;

    alarm_clock_multi #(
        .TICKS_PER_MIN(4),
        .NUM_ALARMS   (4),
        .SNOOZE_MIN   (5),
        .RING_MIN     (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .set_time     (set_time),
        .set_hours    (set_hours),
        .set_minutes  (set_minutes),
        .alarm_wr     (alarm_wr),
        .alarm_idx    (alarm_idx),
        .alarm_hours  (alarm_hours),
        .alarm_minutes(alarm_minutes),
        .alarm_en     (alarm_en),
        .snooze       (snooze),
        .dismiss      (dismiss),
        .cur_hours    (cur_hours),
        .cur_minutes  (cur_minutes),
        .minute_tick  (minute_tick),
        .ringing      (ringing),
        .snoozed      (snoozed),
        .ring_idx     (ring_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit st; int sh; int sm;
        bit aw; int ai; int ah; int am; bit ae;
        bit sn; bit ds; int w;
        int eh; int em; bit et; bit er; bit es; int ei;
    } vec_t;

    localparam int NV = 37;
    vec_t vecs [NV];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic chk_all(input string tag, input int eh, input int em, input bit et,
                           input bit er, input bit es, input int ei);
        chk({tag, ".hours"},    int'(cur_hours),   eh);
        chk({tag, ".minutes"},  int'(cur_minutes), em);
        chk({tag, ".tick"},     int'(minute_tick), int'(et));
        chk({tag, ".ringing"},  int'(ringing),     int'(er));
        chk({tag, ".snoozed"},  int'(snoozed),     int'(es));
        chk({tag, ".ring_idx"}, int'(ring_idx),    ei);
    endtask

    task automatic clear_inputs();
        set_time = 0; set_hours = '0; set_minutes = '0;
        alarm_wr = 0; alarm_idx = '0; alarm_hours = '0; alarm_minutes = '0; alarm_en = 0;
        snooze = 0; dismiss = 0;
    endtask

    initial begin
        //             st sh sm  aw ai ah am ae  sn ds  w   eh em et er es ei
        vecs[0]  = '{1, 23, 59, 0, 0, 0, 0, 0, 0, 0, 0,  23, 59, 0, 0, 0, 0};
        vecs[1]  = '{0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 2,  23, 59, 0, 0, 0, 0};
        vecs[2]  = '{0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0,   0,  0, 1, 0, 0, 0};
        vecs[3]  = '{0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0,   0,  0, 0, 0, 0, 0};
        vecs[4]  = '{1, 24,  0, 0, 0, 0, 0, 0, 0, 0, 0,   0,  0, 0, 0, 0, 0};
        vecs[5]  = '{1, 12, 60, 0, 0, 0, 0, 0, 0, 0, 1,   0,  1, 1, 0, 0, 0};
        vecs[6]  = '{0,  0,  0, 1, 1, 7, 0, 1, 0, 0, 0,   0,  1, 0, 0, 0, 0};
        vecs[7]  = '{0,  0,  0, 1, 2, 7, 0, 1, 0, 0, 0,   0,  1, 0, 0, 0, 0};
        vecs[8]  = '{0,  0,  0, 1, 0, 7, 0, 0, 0, 0, 0,   0,  1, 0, 0, 0, 0};
        vecs[9]  = '{1,  6, 59, 0, 0, 0, 0, 0, 0, 0, 0,   6, 59, 0, 0, 0, 0};
        vecs[10] = '{0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 2,   6, 59, 0, 0, 0, 0};
        vecs[11] = '{0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0,   7,  0, 1, 1, 0, 1};
        vecs[12] = '{0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 3,   7,  1, 1, 1, 0, 1};
        vecs[13] = '{0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 3,   7,  2, 1, 0, 0, 1};
        vecs[14] = '{1,  6, 59, 0, 0, 0, 0, 0, 0, 0, 3,   6, 59, 0, 0, 0, 1};
        vecs[15] = '{0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0,   7,  0, 1, 1, 0, 1};
        vecs[16] = '{0,  0,  0, 0, 0, 0, 0, 0, 1, 0, 0,   7,  0, 0, 0, 1, 1};
        vecs[17] = '{0,  0,  0, 0, 0, 0, 0, 0, 1, 0, 2,   7,  1, 1, 0, 1, 1};
        vecs[18] = '{0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 11,  7,  4, 1, 0, 1, 1};
        vecs[19] = '{0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 3,   7,  5, 1, 1, 0, 1};
        vecs[20] = '{0,  0,  0, 0, 0, 0, 0, 0, 0, 1, 0,   7,  5, 0, 0, 0, 1};
        vecs[21] = '{1,  6, 59, 0, 0, 0, 0, 0, 0, 0, 3,   6, 59, 0, 0, 0, 1};
        vecs[22] = '{0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0,   7,  0, 1, 1, 0, 1};
        vecs[23] = '{0,  0,  0, 0, 0, 0, 0, 0, 1, 1, 0,   7,  0, 0, 0, 0, 1};
        vecs[24] = '{1,  6, 59, 0, 0, 0, 0, 0, 0, 0, 3,   6, 59, 0, 0, 0, 1};
        vecs[25] = '{0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0,   7,  0, 1, 1, 0, 1};
        vecs[26] = '{0,  0,  0, 0, 0, 0, 0, 0, 1, 0, 0,   7,  0, 0, 0, 1, 1};
        vecs[27] = '{0,  0,  0, 0, 0, 0, 0, 0, 0, 1, 0,   7,  0, 0, 0, 0, 1};
        vecs[28] = '{0,  0,  0, 0, 0, 0, 0, 0, 1, 0, 0,   7,  0, 0, 0, 0, 1};
        vecs[29] = '{0,  0,  0, 1, 0, 8, 0, 0, 0, 0, 0,   7,  1, 1, 0, 0, 1};
        vecs[30] = '{1,  7, 59, 0, 0, 0, 0, 0, 0, 0, 3,   7, 59, 0, 0, 0, 1};
        vecs[31] = '{0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0,   8,  0, 1, 0, 0, 1};
        vecs[32] = '{0,  0,  0, 1, 0, 8, 0, 1, 0, 0, 0,   8,  0, 0, 0, 0, 1};
        vecs[33] = '{1,  8,  0, 0, 0, 0, 0, 0, 0, 0, 3,   8,  0, 0, 0, 0, 1};
        vecs[34] = '{1,  7, 59, 0, 0, 0, 0, 0, 0, 0, 3,   7, 59, 0, 0, 0, 1};
        vecs[35] = '{0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0,   8,  0, 1, 1, 0, 0};
        vecs[36] = '{0,  0,  0, 1, 0, 9, 0, 0, 0, 0, 0,   8,  0, 0, 1, 0, 0};

        rst_n = 1'b0;
        clear_inputs();
        #12;
        chk_all("reset", 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;

        // First tick lands on the 4th edge after release, second on the 8th.
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("cyc%0d.tick", k), int'(minute_tick), (k % 4 == 0) ? 1 : 0);
            chk($sformatf("cyc%0d.minutes", k), int'(cur_minutes), k / 4);
            chk($sformatf("cyc%0d.hours", k), int'(cur_hours), 0);
        end

        for (int i = 0; i < NV; i++) begin
            set_time      = vecs[i].st;
            set_hours     = 5'(vecs[i].sh);
            set_minutes   = 6'(vecs[i].sm);
            alarm_wr      = vecs[i].aw;
            alarm_idx     = 2'(vecs[i].ai);
            alarm_hours   = 5'(vecs[i].ah);
            alarm_minutes = 6'(vecs[i].am);
            alarm_en      = vecs[i].ae;
            snooze        = vecs[i].sn;
            dismiss       = vecs[i].ds;
            @(posedge clk);
            #1;
            clear_inputs();
            repeat (vecs[i].w) @(posedge clk);
            #1;
            chk_all($sformatf("vec%0d", i), vecs[i].eh, vecs[i].em, vecs[i].et,
                    vecs[i].er, vecs[i].es, vecs[i].ei);
        end

        // Still ringing from slot 0; pull reset in mid-cycle and look before the next edge.
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("midring_rst", 0, 0, 0, 0, 0, 0);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_all("post_rst", 0, 0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alarm_clock_multi.md
Name: alarm_clock_multi

Overview:
- Parametrised successor to the team's single-alarm clock core.
- Keeps a 24-hour HH:MM time of day, advanced by an internal minute prescaler.
- Holds NUM_ALARMS independently programmable and enableable alarms, with snooze, dismiss and auto-timeout.
- Sits behind the TinyTapeout top wrapper, which maps ui_in/uio_in onto the programming ports and drives uo_out from the time and ring outputs.

Parameters:
- TICKS_PER_MIN, 60, clk cycles per minute tick (≥2). Benches use 4.
- NUM_ALARMS, 4, number of alarm slots (≥1).
- SNOOZE_MIN, 5, minutes spent snoozed before re-ringing (≥1).
- RING_MIN, 2, minutes of ringing before auto-dismiss (≥1).
- IDXW, max(1,$clog2(NUM_ALARMS)), alarm index width (derived).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- set_time  in  1  one-cycle strobe: load time from set_hours/set_minutes
- set_hours  in  5  hours to load, 0..23
- set_minutes  in  6  minutes to load, 0..59
- alarm_wr  in  1  one-cycle strobe: write alarm slot alarm_idx
- alarm_idx  in  IDXW  slot to write
- alarm_hours  in  5  alarm hours, 0..23
- alarm_minutes  in  6  alarm minutes, 0..59
- alarm_en  in  1  enable bit written with the slot
- snooze  in  1  level-sampled snooze request
- dismiss  in  1  level-sampled dismiss request
- cur_hours  out  5  current hours
- cur_minutes  out  6  current minutes
- minute_tick  out  1  one-cycle pulse on each minute advance
- ringing  out  1  high while in RINGING
- snoozed  out  1  high while in SNOOZED
- ring_idx  out  IDXW  slot that caused the current ring/snooze

Behaviour:
- Reset (async, rst_n=0) clears all of the following:
  - time 00:00, prescaler 0, minute_tick 0;
  - every alarm slot to 00:00, disabled;
  - FSM to IDLE; ringing/snoozed 0; ring_idx 0; snooze/ring counters 0.
- All outputs are registered.
- Prescaler:
  - Counts 0..TICKS_PER_MIN-1.
  - On the edge where it equals TICKS_PER_MIN-1, it returns to 0, minute_tick goes high for one cycle, and the time advances.
  - First tick after reset lands on cycle TICKS_PER_MIN.
- Time advance: minutes+1; 59 wraps to 0 with hours+1; 23:59 wraps to 00:00.
- set_time:
  - Takes priority over a coincident advance.
  - Loads time and clears the prescaler; minute_tick is suppressed that cycle.
  - Out-of-range values (hours>23 or minutes>59) are ignored entirely: time and prescaler are unchanged and the advance proceeds normally.
  - A loaded time never triggers an alarm match.
- alarm_wr:
  - Writes {hours, minutes, en} to slot alarm_idx.
  - Ignored if values are out of range or alarm_idx ≥ NUM_ALARMS.
  - Does not affect an in-progress ring or snooze.
- Match:
  - Evaluated only on advance edges, against the next time value.
  - Slot k matches if enabled and its HH:MM equals the next time.
  - With several matches, the lowest index wins.
- FSM states IDLE, RINGING, SNOOZED, with the following transitions:
  - IDLE→RINGING: on a match edge. ring_idx is set to the matched slot and the ring counter is cleared. ringing rises in the same cycle that cur_* first shows the alarm time.
  - In RINGING:
    - dismiss → IDLE.
    - else snooze → SNOOZED, snooze counter cleared.
    - else count minute ticks; when the ring counter reaches RING_MIN → IDLE (auto-dismiss).
  - In SNOOZED:
    - dismiss → IDLE.
    - else count minute ticks; when the snooze counter reaches SNOOZE_MIN → RINGING, ring counter cleared.
    - snooze is ignored in this state.
  - Dismiss beats snooze when both are high.
  - Matches while RINGING or SNOOZED are dropped, not queued.
  - snooze/dismiss in IDLE have no effect.
  - A match on the same edge as a transition to IDLE is dropped. The FSM re-arms on the next cycle, so the next match occurs a full day later.
- ring_idx holds its value after returning to IDLE until the next ring.
- Reset mid-ring returns to IDLE immediately and asynchronously.

Test Plan:
- Reset/tick, TICKS_PER_MIN=4:
  - Stimulus: release reset, count cycles.
  - Required: cur=00:00 through cycle 3; minute_tick pulses at cycles 4 and 8; cur=00:01 then 00:02.
- Wrap:
  - Stimulus: set_time 23:59, wait one tick.
  - Required: cur=00:00, minute_tick=1 for one cycle.
  - Stimulus: set_time 24:00.
  - Required: ignored, time keeps advancing.
- Priority match:
  - Stimulus: slots 1 and 2 both set to 07:00 enabled, time 06:59.
  - Required: on advance to 07:00, ringing=1 and ring_idx=1.
  - With RING_MIN=2 and no input: ringing falls at 07:02.
- Snooze cycle:
  - Stimulus: ringing at 07:00, pulse snooze.
  - Required: snoozed=1, ringing=0; ringing returns at 07:05 (SNOOZE_MIN=5); dismiss then gives IDLE.
  - Stimulus: snooze and dismiss asserted together.
  - Required: IDLE.
- Disabled/loaded-time:
  - Stimulus: slot 0 set to 08:00 with en=0, advance through 08:00.
  - Required: no ring.
  - Stimulus: enable slot 0, then set_time 08:00.
  - Required: no ring.
- Reset mid-ring:
  - Stimulus: assert rst_n=0 mid-cycle while ringing.
  - Required: ringing=0 and cur=00:00 before the next edge.
